pcie_rst_requester: RTL and testbench

Application-side reset requester for the PCIe hard IP reset path. Watches the LTSSM state, runs a link-training watchdog, and accepts software reset requests. When either fires, it drives a timed active-low reset request, `npor_req_n`, which is ANDed into the HIP reset generator's `npor`. It then waits for that generator to release `app_rstn` before re-arming, and latches a sticky failure after repeated unsuccessful retries.

---
 rtl/pcie_rst_requester.sv | 242 ++++++++++++++++++++++++
 tb/tb_pcie_rst_requester.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rst_requester.sv
// ---------------------------------------------------------------------------
// pcie_rst_requester
//
// Application-side reset requester for the PCIe hard IP reset path.
// It watches the LTSSM, runs a link-training watchdog and accepts software
// reset requests. When one of them fires, it drives a timed active-low
// request (npor_req_n) that is ANDed into the HIP reset generator's npor.
// It then waits for the generator to release app_rstn and backs off before
// re-arming. Repeated watchdog-caused resets end in a sticky failure.
//
// Build option:
//   PCIE_RST_REQ_WDT_EN - when defined, the watchdog expiry, the retry
//                         counter and the FAIL state are compiled in. When
//                         undefined, only sw_req can cause a reset request,
//                         retry_cnt and fail are tied to 0.
//
// Parameters:
//   WDT_CYCLES     - cycles without L0 before the watchdog fires (2..2^24-1)
//   HOLD_CYCLES    - width of the npor_req_n low pulse (1..2^24-1)
//   BACKOFF_CYCLES - delay after app_rstn rises before re-arming (1..2^24-1)
//   MAX_RETRY      - watchdog-caused resets allowed before FAIL (1..7)
//
// Ports:
//   pld_clk     in   clock
//   any_rstn_rr in   asynchronous active-low reset
//   ltssm       in   raw HIP LTSSM state [4:0]
//   app_rstn    in   application reset from the HIP generator, 1 = released
//   sw_req      in   single-cycle software reset request
//   sw_ack      out  single-cycle acknowledge of an accepted sw_req
//   npor_req_n  out  reset request to the reset generator, active-low
//   link_up     out  registered (ltssm_r == L0)
//   retry_cnt   out  count of watchdog-caused resets [2:0], saturating
//   fail        out  sticky retry-exhaustion flag
//   state       out  current FSM state code [2:0]
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pcie_rst_requester #(
    parameter logic [23:0] WDT_CYCLES     = 24'd1000000,
    parameter int unsigned HOLD_CYCLES    = 64,
    parameter int unsigned BACKOFF_CYCLES = 1024,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       pld_clk,
    input  logic       any_rstn_rr,
    input  logic [4:0] ltssm,
    input  logic       app_rstn,
    input  logic       sw_req,
    output logic       sw_ack,
    output logic       npor_req_n,
    output logic       link_up,
    output logic [2:0] retry_cnt,
    output logic       fail,
    output logic [2:0] state
);

    // LTSSM encoding of L0 on the HIP
    localparam logic [4:0] LTSSM_L0 = 5'h0F;

    // Terminal timer values; the timer starts at 0 on state entry, so a
    // phase lasting N cycles ends when the timer reads N-1.
    localparam logic [23:0] HOLD_LAST    = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] BACKOFF_LAST = 24'(BACKOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_WAIT_L0  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ASSERT   = 3'd2,
        ST_RECOVER  = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    // Catch illegal configurations at elaboration rather than in silicon.
    generate
        if ((WDT_CYCLES < 24'd2) ||
            (HOLD_CYCLES < 1) || (HOLD_CYCLES > 32'h00FF_FFFF) ||
            (BACKOFF_CYCLES < 1) || (BACKOFF_CYCLES > 32'h00FF_FFFF) ||
            (MAX_RETRY < 1) || (MAX_RETRY > 7)) begin : gBadConfig
            $error("pcie_rst_requester: parameter out of range");
        end
    endgenerate

    state_t      r_state;
    state_t      w_nextState;
    logic [23:0] r_timer;
    logic [23:0] w_nextTimer;
    logic [4:0]  r_ltssm;
    logic        r_linkUp;
    logic        r_npor;
    logic        r_swAck;
    logic        w_swAccept;

`ifdef PCIE_RST_REQ_WDT_EN
    localparam logic [23:0] WDT_LAST    = WDT_CYCLES - 24'd1;
    localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

    logic [2:0]  r_retryCnt;
    logic [2:0]  w_nextRetryCnt;
    logic        r_fail;
    logic        w_nextFail;
`endif

    // LTSSM input pipeline: one stage to register the raw HIP state, a
    // second to produce link_up, giving a two-cycle ltssm -> link_up path.
    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_ltssm  <= 5'd0;
            r_linkUp <= 1'b0;
        end else begin
            r_ltssm  <= ltssm;
            r_linkUp <= (r_ltssm == LTSSM_L0);
        end
    end

    // Next-state, timer and counter logic. sw_req is checked first in every
    // accepting state so a software cause always wins over link_up and the
    // watchdog and never touches the retry counter.
    always_comb begin
        w_nextState = r_state;
        w_swAccept  = 1'b0;
`ifdef PCIE_RST_REQ_WDT_EN
        w_nextRetryCnt = r_retryCnt;
        w_nextFail     = r_fail;
`endif

        case (r_state)
            ST_WAIT_L0: begin
                if (sw_req) begin
                    w_nextState = ST_ASSERT;
                    w_swAccept  = 1'b1;
                end else if (r_linkUp) begin
                    w_nextState = ST_IDLE;
`ifdef PCIE_RST_REQ_WDT_EN
                    w_nextRetryCnt = 3'd0;
                end else if (r_timer == WDT_LAST) begin
                    if (r_retryCnt == RETRY_LIMIT) begin
                        w_nextState = ST_FAIL;
                        w_nextFail  = 1'b1;
                    end else begin
                        w_nextState    = ST_ASSERT;
                        w_nextRetryCnt = r_retryCnt + 3'd1;
                    end
`endif
                end
            end

            ST_IDLE: begin
                if (sw_req) begin
                    w_nextState = ST_ASSERT;
                    w_swAccept  = 1'b1;
                end else if (!r_linkUp) begin
                    w_nextState = ST_WAIT_L0;
                end
            end

            ST_ASSERT: begin
                if (r_timer == HOLD_LAST) begin
                    w_nextState = ST_RECOVER;
                end
            end

            ST_RECOVER: begin
                if (app_rstn && (r_timer == BACKOFF_LAST)) begin
                    w_nextState = ST_WAIT_L0;
                end
            end

            ST_FAIL: begin
                // link_up is deliberately ignored here; only software can
                // restart a requester that has given up.
                if (sw_req) begin
                    w_nextState = ST_ASSERT;
                    w_swAccept  = 1'b1;
`ifdef PCIE_RST_REQ_WDT_EN
                    w_nextFail     = 1'b0;
                    w_nextRetryCnt = 3'd0;
`endif
                end
            end

            default: begin
                w_nextState = ST_WAIT_L0;
            end
        endcase
    end

    // Shared timer: cleared on every transition, otherwise advanced or held
    // according to the current state. In RECOVER it only runs while the
    // generator holds app_rstn released, and restarts if app_rstn drops.
    always_comb begin
        w_nextTimer = 24'd0;
        if (w_nextState == r_state) begin
            case (r_state)
                ST_WAIT_L0: w_nextTimer = r_timer + 24'd1;
                ST_ASSERT:  w_nextTimer = r_timer + 24'd1;
                ST_RECOVER: w_nextTimer = app_rstn ? (r_timer + 24'd1) : 24'd0;
                default:    w_nextTimer = 24'd0;
            endcase
        end
    end

    // State, timer and registered outputs. npor_req_n is derived from the
    // next state so that it falls in the same cycle the FSM enters ASSERT.
    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_state <= ST_WAIT_L0;
            r_timer <= 24'd0;
            r_npor  <= 1'b1;
            r_swAck <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_timer <= w_nextTimer;
            r_npor  <= (w_nextState != ST_ASSERT);
            r_swAck <= w_swAccept;
        end
    end

`ifdef PCIE_RST_REQ_WDT_EN
    // Retry bookkeeping only exists when the watchdog is built in.
    always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
        if (!any_rstn_rr) begin
            r_retryCnt <= 3'd0;
            r_fail     <= 1'b0;
        end else begin
            r_retryCnt <= w_nextRetryCnt;
            r_fail     <= w_nextFail;
        end
    end

    assign retry_cnt = r_retryCnt;
    assign fail      = r_fail;
`else
    assign retry_cnt = 3'd0;
    assign fail      = 1'b0;
`endif

    assign sw_ack     = r_swAck;
    assign npor_req_n = r_npor;
    assign link_up    = r_linkUp;
    assign state      = r_state;

endmodule

// File: tb/tb_pcie_rst_requester.sv
// ---------------------------------------------------------------------------
// tb_pcie_rst_requester
//
// Directed bench for pcie_rst_requester with WDT_CYCLES=100, HOLD_CYCLES=8,
// BACKOFF_CYCLES=16, MAX_RETRY=2. Every reset pulse the bench provokes is
// pushed onto a scoreboard with its expected start cycle and width; a
// monitor measures pulses on npor_req_n and pops/compares them. Watchdog
// sections are only built when PCIE_RST_REQ_WDT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pcie_rst_requester;

    logic       pld_clk;
    logic       any_rstn_rr;
    logic [4:0] ltssm;
    logic       app_rstn;
    logic       sw_req;
    logic       sw_ack;
    logic       npor_req_n;
    logic       link_up;
    logic [2:0] retry_cnt;
    logic       fail;
    logic [2:0] state;

    typedef struct {
        int    width;
        int    fallCyc;
        string tag;
    } pulseExp_t;

    pulseExp_t expQ[$];

    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   lowCount = 0;
    int   fallCyc  = 0;
    logic sawLow   = 1'b0;

    int n;
    int e0;
    int e2;
`ifdef PCIE_RST_REQ_WDT_EN
    int e3;
    int e4;
    int e5;
    int e6;
`endif

    pcie_rst_requester #(
        .WDT_CYCLES     (24'd100),
        .HOLD_CYCLES    (8),
        .BACKOFF_CYCLES (16),
        .MAX_RETRY      (2)
    ) dut (
        .pld_clk     (pld_clk),
        .any_rstn_rr (any_rstn_rr),
        .ltssm       (ltssm),
        .app_rstn    (app_rstn),
        .sw_req      (sw_req),
        .sw_ack      (sw_ack),
        .npor_req_n  (npor_req_n),
        .link_up     (link_up),
        .retry_cnt   (retry_cnt),
        .fail        (fail),
        .state       (state)
    );

    // 10 ns clock
    initial begin
        pld_clk = 1'b0;
        forever #5 pld_clk = ~pld_clk;
    end

    // Cycle number = count of rising edges seen so far
    always @(posedge pld_clk) begin
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic swReq, input logic [4:0] ltssmVal,
                                 input logic appRstn);
        sw_req   = swReq;
        ltssm    = ltssmVal;
        app_rstn = appRstn;
    endtask

    task automatic expectPulse(input int width, input int fall, input string tag);
        pulseExp_t item;
        item.width   = width;
        item.fallCyc = fall;
        item.tag     = tag;
        expQ.push_back(item);
    endtask

    task automatic tick(input int count);
        repeat (count) @(posedge pld_clk);
        #1;
    endtask

    // Pulse monitor: measures each low pulse on npor_req_n at the falling
    // clock edge and compares it against the oldest scoreboard entry.
    always @(negedge pld_clk) begin
        pulseExp_t item;
        if (npor_req_n === 1'b0) begin
            if (lowCount == 0) fallCyc = cyc;
            lowCount++;
            sawLow = 1'b1;
        end else if (lowCount != 0) begin
            tests++;
            assert (expQ.size() != 0)
            else begin
                fails++;
                $error("[TB] FAIL unexpectedPulse observed width=%0d at cycle %0d expected no pulse",
                       lowCount, fallCyc);
            end
            if (expQ.size() != 0) begin
                item = expQ.pop_front();
                checkOutput({item.tag, "_width"}, 32'(lowCount), 32'(item.width));
                checkOutput({item.tag, "_start"}, 32'(fallCyc), 32'(item.fallCyc));
            end
            lowCount = 0;
        end
    end

    initial begin
        any_rstn_rr = 1'b0;
        applyStimulus(1'b0, 5'h00, 1'b1);

        // Reset values
        tick(3);
        checkOutput("rstState",  32'(state),      32'd0);
        checkOutput("rstNpor",   32'(npor_req_n), 32'd1);
        checkOutput("rstAck",    32'(sw_ack),     32'd0);
        checkOutput("rstLinkUp", 32'(link_up),    32'd0);
        checkOutput("rstRetry",  32'(retry_cnt),  32'd0);
        checkOutput("rstFail",   32'(fail),       32'd0);
        any_rstn_rr = 1'b1;
        e0 = cyc;

        // Link trains: ltssm = L0 at cycle 10, link_up at 12, IDLE at 13
        tick(10);
        applyStimulus(1'b0, 5'h0F, 1'b1);
        tick(1);
        checkOutput("linkUpAt11", 32'(link_up), 32'd0);
        tick(1);
        checkOutput("linkUpAt12", 32'(link_up), 32'd1);
        checkOutput("stateAt12",  32'(state),   32'd0);
        tick(1);
        checkOutput("idleAt13",   32'(state),   32'd1);

        // Software request from IDLE; a second request during ASSERT is
        // dropped and must not stretch the pulse.
        n = cyc;
        expectPulse(8, n + 1, "swPulse");
        applyStimulus(1'b1, 5'h0F, 1'b1);
        tick(1);
        applyStimulus(1'b0, 5'h0F, 1'b1);
        checkOutput("swAck",       32'(sw_ack),     32'd1);
        checkOutput("swNporLow",   32'(npor_req_n), 32'd0);
        checkOutput("swAssert",    32'(state),      32'd2);
        tick(2);
        applyStimulus(1'b1, 5'h0F, 1'b1);
        tick(1);
        applyStimulus(1'b0, 5'h0F, 1'b1);
        checkOutput("swInAssertNoAck", 32'(sw_ack), 32'd0);
        checkOutput("swInAssertState", 32'(state),  32'd2);
        tick(20);
        checkOutput("backoffStill", 32'(state), 32'd3);
        tick(1);
        checkOutput("backoffDone",  32'(state), 32'd0);
        tick(1);
        checkOutput("reIdle",       32'(state), 32'd1);

        // Link drop: link_up falls two cycles later, WAIT_L0 the cycle after
        applyStimulus(1'b0, 5'h10, 1'b1);
        tick(2);
        checkOutput("dropLinkUp", 32'(link_up), 32'd0);
        checkOutput("dropIdle",   32'(state),   32'd1);
        tick(1);
        checkOutput("dropWait",   32'(state),   32'd0);
        e2 = cyc;

`ifdef PCIE_RST_REQ_WDT_EN
        // Watchdog restarts from 0 at WAIT_L0 entry; generator holds
        // app_rstn low through the pulse and for a while afterwards.
        expectPulse(8, e2 + 100, "wdtPulse1");
        tick(99);
        checkOutput("wdtBeforeExpiry", 32'(state), 32'd0);
        applyStimulus(1'b0, 5'h02, 1'b0);
        tick(1);
        checkOutput("wdtAssert",  32'(state),     32'd2);
        checkOutput("wdtRetry1",  32'(retry_cnt), 32'd1);
        checkOutput("wdtNoAck",   32'(sw_ack),    32'd0);
        tick(8);
        checkOutput("wdtRecover", 32'(state),     32'd3);
        tick(10);
        checkOutput("recoverHeld", 32'(state),    32'd3);
        applyStimulus(1'b0, 5'h02, 1'b1);
        tick(15);
        checkOutput("recoverAt15", 32'(state),    32'd3);
        tick(1);
        checkOutput("recoverAt16", 32'(state),    32'd0);
        e3 = cyc;

        // Second watchdog pulse
        expectPulse(8, e3 + 100, "wdtPulse2");
        tick(100);
        checkOutput("wdtRetry2", 32'(retry_cnt), 32'd2);
        tick(24);
        checkOutput("wdt2Rearm", 32'(state),     32'd0);
        e4 = cyc;

        // Third expiry exhausts retries: FAIL, no pulse
        tick(99);
        checkOutput("failNotYet", 32'(state), 32'd0);
        tick(1);
        checkOutput("failState",  32'(state),      32'd4);
        checkOutput("failFlag",   32'(fail),       32'd1);
        checkOutput("failRetry",  32'(retry_cnt),  32'd2);
        checkOutput("failNpor",   32'(npor_req_n), 32'd1);
        applyStimulus(1'b0, 5'h0F, 1'b1);
        tick(5);
        checkOutput("failLinkUp",  32'(link_up), 32'd1);
        checkOutput("failIgnoreL0", 32'(state),  32'd4);
        applyStimulus(1'b0, 5'h02, 1'b1);
        tick(3);
        checkOutput("failStays",   32'(state),   32'd4);

        // Software restart out of FAIL
        n = cyc;
        expectPulse(8, n + 1, "failSwPulse");
        applyStimulus(1'b1, 5'h02, 1'b1);
        tick(1);
        applyStimulus(1'b0, 5'h02, 1'b1);
        checkOutput("failSwAck",   32'(sw_ack),    32'd1);
        checkOutput("failCleared", 32'(fail),      32'd0);
        checkOutput("retryCleared", 32'(retry_cnt), 32'd0);
        checkOutput("failSwAssert", 32'(state),    32'd2);
        tick(24);
        checkOutput("failSwRearm", 32'(state),     32'd0);
        e5 = cyc;

        // sw_req in the same cycle as watchdog expiry: software wins
        tick(99);
        expectPulse(8, e5 + 100, "simulPulse");
        applyStimulus(1'b1, 5'h02, 1'b1);
        tick(1);
        applyStimulus(1'b0, 5'h02, 1'b1);
        checkOutput("simulAck",   32'(sw_ack),    32'd1);
        checkOutput("simulRetry", 32'(retry_cnt), 32'd0);
        checkOutput("simulState", 32'(state),     32'd2);
        tick(24);
        checkOutput("simulRearm", 32'(state),     32'd0);
`endif

        // Reset in the middle of ASSERT after the fourth low cycle
        n = cyc;
        expectPulse(4, n + 1, "rstMidPulse");
        applyStimulus(1'b1, ltssm, 1'b1);
        tick(1);
        applyStimulus(1'b0, 5'h0F, 1'b1);
        checkOutput("rstMidAck", 32'(sw_ack), 32'd1);
        tick(3);
        checkOutput("rstMidLinkUp", 32'(link_up), 32'd1);
        @(negedge pld_clk);
        #1;
        any_rstn_rr = 1'b0;
        #1;
        checkOutput("rstMidNpor",   32'(npor_req_n), 32'd1);
        checkOutput("rstMidState",  32'(state),      32'd0);
        checkOutput("rstMidAckClr", 32'(sw_ack),     32'd0);
        checkOutput("rstMidLink",   32'(link_up),    32'd0);
        checkOutput("rstMidRetry",  32'(retry_cnt),  32'd0);
        checkOutput("rstMidFail",   32'(fail),       32'd0);
        applyStimulus(1'b0, 5'h02, 1'b1);
        tick(2);
        @(posedge pld_clk);
        #1;
        any_rstn_rr = 1'b1;

`ifdef PCIE_RST_REQ_WDT_EN
        // Watchdog runs from 0 again after reset
        e6 = cyc;
        expectPulse(8, e6 + 100, "wdtAfterReset");
        tick(100);
        checkOutput("wdtAfterRstNpor",  32'(npor_req_n), 32'd0);
        checkOutput("wdtAfterRstRetry", 32'(retry_cnt),  32'd1);
        tick(24);
        checkOutput("wdtAfterRstRearm", 32'(state),      32'd0);
`else
        // Without the watchdog a stuck LTSSM never causes a pulse
        sawLow = 1'b0;
        tick(1000);
        checkOutput("noWdtNoPulse", 32'(sawLow),    32'd0);
        checkOutput("noWdtState",   32'(state),     32'd0);
        checkOutput("noWdtRetry",   32'(retry_cnt), 32'd0);
        checkOutput("noWdtFail",    32'(fail),      32'd0);
`endif

        tick(2);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
